// File: rtl/fifo_rd_stream_adapter_pkg.sv
// Local constants shared by the FIFO read-side stream adapter and its output buffer.
package fifo_rd_stream_adapter_pkg;
  localparam int BUF_DEPTH = 3;
  localparam int CNT_W     = 2;
  localparam int BEAT_W    = 16;
endpackage

// File: rtl/fifo_rd_stream_adapter_stream_buf3.sv
// Three-entry register FIFO; entry 0 is always the head so the output needs no read mux.
module stream_buf3
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      wr_idx;

  // A simultaneous pop shifts everything down one slot, so the new tail lands one lower.
  always_comb wr_idx = pop ? cnt_q - 2'd1 : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < BUF_DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      if (push && (wr_idx < CNT_W'(BUF_DEPTH))) mem[wr_idx] <= push_data;
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head_data = mem[0];
  assign count     = cnt_q;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Turns the registered-read FIFO interface into a full-rate valid/ready stream with burst-last marking.
module fifo_rd_stream_adapter
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic                  FIFO_RD_EN,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  input  logic                  FIFO_RD_EMPTY,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  M_LAST,
  output logic [1:0]            BUF_CNT
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic              run_q;
  logic              pend_q;
  logic [BEAT_W-1:0] beat_q;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        committed;
  logic              pop;

  // Issue only when the buffer can absorb this read on top of any read already in flight;
  // depends on registers and the empty flag alone, never on M_READY.
  assign committed  = {1'b0, cnt} + {2'b00, pend_q};
  assign FIFO_RD_EN = run_q & ~FIFO_RD_EMPTY & (committed <= 3'd2);

  assign M_VALID = (cnt != '0);
  assign pop     = M_VALID & M_READY;
  assign M_LAST  = M_VALID & (beat_q == LAST_BEAT);
  assign BUF_CNT = cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run_q  <= 1'b0;
      pend_q <= 1'b0;
      beat_q <= '0;
    end else begin
      run_q  <= 1'b1;
      pend_q <= FIFO_RD_EN;
      if (pop) beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 16'd1;
    end
  end

  stream_buf3 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (CLK),
    .rst      (RST),
    .push     (pend_q),
    .push_data(FIFO_RD_DATA),
    .pop      (pop),
    .head_data(M_DATA),
    .count    (cnt)
  );

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: queue-based FIFO model, scoreboard monitor and scenario tasks.
module tb_fifo_rd_stream_adapter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd_en;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_last;
  logic [1:0] buf_cnt;

  // Free-running sources for the short-burst instances.
  logic       b1_rd, b1_valid, b1_last, b3_rd, b3_valid, b3_last;
  logic [7:0] b1_src, b1_data, b3_src, b3_data, b1_ctr, b3_ctr;
  logic [1:0] b1_cnt, b3_cnt;
  logic       ready_b = 1'b1;

  int tests = 0;
  int fails = 0;
  int beats_seen = 0;
  int lasts_seen = 0;
  int rd_seen = 0;
  int beat_idx = 0;
  logic [7:0] first_data = 8'h00;

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_rd_stream_adapter #(.DATA_WIDTH(8), .BURST_LEN(16)) dut (
    .CLK(clk), .RST(rst), .FIFO_RD_EN(rd_en), .FIFO_RD_DATA(fifo_data),
    .FIFO_RD_EMPTY(fifo_empty), .M_VALID(m_valid), .M_READY(m_ready),
    .M_DATA(m_data), .M_LAST(m_last), .BUF_CNT(buf_cnt)
  );

  fifo_rd_stream_adapter #(.DATA_WIDTH(8), .BURST_LEN(1)) dut_b1 (
    .CLK(clk), .RST(rst), .FIFO_RD_EN(b1_rd), .FIFO_RD_DATA(b1_src),
    .FIFO_RD_EMPTY(1'b0), .M_VALID(b1_valid), .M_READY(ready_b),
    .M_DATA(b1_data), .M_LAST(b1_last), .BUF_CNT(b1_cnt)
  );

  fifo_rd_stream_adapter #(.DATA_WIDTH(8), .BURST_LEN(3)) dut_b3 (
    .CLK(clk), .RST(rst), .FIFO_RD_EN(b3_rd), .FIFO_RD_DATA(b3_src),
    .FIFO_RD_EMPTY(1'b0), .M_VALID(b3_valid), .M_READY(ready_b),
    .M_DATA(b3_data), .M_LAST(b3_last), .BUF_CNT(b3_cnt)
  );

  // Registered-read FIFO: data appears the cycle after rd_en is sampled.
  always @(posedge clk) begin
    if (rd_en && src_q.size() > 0) fifo_data <= src_q.pop_front();
    fifo_empty <= (src_q.size() == 0);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      b1_ctr <= 8'h00; b1_src <= 8'h00;
    end else if (b1_rd) begin
      b1_src <= b1_ctr; b1_ctr <= b1_ctr + 8'h01;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      b3_ctr <= 8'h00; b3_src <= 8'h00;
    end else if (b3_rd) begin
      b3_src <= b3_ctr; b3_ctr <= b3_ctr + 8'h01;
    end
  end

  task automatic push(input logic [7:0] v);
    src_q.push_back(v);
    exp_q.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_beats(input int n, input int bound, input string name);
    int t = 0;
    while (beats_seen < n && t < bound) begin tick(); t++; end
    tests++;
    if (beats_seen != n) begin
      fails++;
      $display("FAIL %s: beats %0d, required %0d", name, beats_seen, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_ready = 1'b0;
    src_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Scoreboard: every accepted beat must be the next byte written, with M_LAST every 16th beat.
  task automatic monitor();
    logic [7:0] prev_data = 8'h00;
    logic       prev_hold = 1'b0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        beats_seen = 0; lasts_seen = 0; rd_seen = 0; beat_idx = 0; prev_hold = 1'b0;
      end else begin
        if (rd_en) begin
          rd_seen++;
          tests++;
          if (fifo_empty !== 1'b0) begin
            fails++;
            $display("FAIL rd_en_while_empty: empty=%b, required 0", fifo_empty);
          end
        end
        if (prev_hold) begin
          tests++;
          if (m_data !== prev_data) begin
            fails++;
            $display("FAIL data_hold: %h, required %h", m_data, prev_data);
          end
        end
        if (m_valid && m_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL stale_beat: got %h, required no beat", m_data);
          end else begin
            e = exp_q.pop_front();
            if (m_data !== e) begin
              fails++;
              $display("FAIL beat_data[%0d]: %h, required %h", beat_idx, m_data, e);
            end
          end
          tests++;
          if (m_last !== ((beat_idx % 16) == 15)) begin
            fails++;
            $display("FAIL beat_last[%0d]: %b, required %b", beat_idx, m_last, (beat_idx % 16) == 15);
          end
          if (m_last) lasts_seen++;
          if (beats_seen == 0) first_data = m_data;
          beats_seen++;
          beat_idx++;
        end
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    push(8'h5A);
    @(negedge clk);
    tests++;
    if ({rd_en, m_valid, m_last, buf_cnt, m_data} !== 13'h0) begin
      fails++;
      $display("FAIL reset_outputs: en=%b v=%b l=%b cnt=%0d d=%h, required all 0",
               rd_en, m_valid, m_last, buf_cnt, m_data);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (rd_en !== 1'b0) begin
      fails++;
      $display("FAIL rd_en_first_cycle: %b, required 0", rd_en);
    end
    @(negedge clk);
    tests++;
    if (rd_en !== 1'b1) begin
      fails++;
      $display("FAIL rd_en_second_cycle: %b, required 1", rd_en);
    end
    m_ready = 1'b1;
    wait_beats(1, 10, "reset_drain");
  endtask

  task automatic test_basic_order();
    logic [7:0] v [4] = '{8'hAA, 8'h55, 8'hCC, 8'h33};
    int rise = -1;
    int val = -1;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(v[i]);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rd_en && rise < 0) rise = c;
      if (m_valid && val < 0) val = c;
    end
    tests++;
    if (rise < 0 || val - rise != 2) begin
      fails++;
      $display("FAIL basic_latency: %0d cycles, required 2", val - rise);
    end
    tick();
    tests++;
    if (beats_seen != 4 || buf_cnt !== 2'd0) begin
      fails++;
      $display("FAIL basic_done: beats=%0d cnt=%0d, required 4 and 0", beats_seen, buf_cnt);
    end
  endtask

  task automatic test_throughput();
    int vcnt = 0;
    int gaps = 0;
    bit started = 0;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 40; i++) push(8'(i));
    for (int c = 0; c < 120 && vcnt < 40; c++) begin
      @(negedge clk);
      if (m_valid) begin started = 1; vcnt++; end
      else if (started) gaps++;
    end
    tests++;
    if (vcnt != 40 || gaps != 0) begin
      fails++;
      $display("FAIL throughput: beats=%0d gaps=%0d, required 40 and 0", vcnt, gaps);
    end
    tick();
    tests++;
    if (lasts_seen != 2) begin
      fails++;
      $display("FAIL throughput_last: %0d lasts, required 2", lasts_seen);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] first;
    do_reset();
    m_ready = 1'b0;
    first = 8'($urandom);
    push(first);
    for (int i = 1; i < 8; i++) push(8'($urandom));
    repeat (10) @(negedge clk);
    tests++;
    if (rd_seen != 3 || buf_cnt !== 2'd3) begin
      fails++;
      $display("FAIL bp_fill: reads=%0d cnt=%0d, required 3 and 3", rd_seen, buf_cnt);
    end
    tests++;
    if (m_data !== first || m_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_head: %h valid=%b, required %h valid=1", m_data, m_valid, first);
    end
    tick();
    m_ready = 1'b1;
    wait_beats(8, 40, "bp_release");
  endtask

  task automatic test_empty_boundary();
    int vis = 0;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(8'($urandom));
    wait_beats(3, 30, "empty_drain");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (m_valid || buf_cnt != 2'd0) vis++;
    end
    tests++;
    if (vis != 0) begin
      fails++;
      $display("FAIL empty_idle: %0d busy cycles, required 0", vis);
    end
    push(8'($urandom));
    push(8'($urandom));
    wait_beats(5, 20, "empty_resume");
  endtask

  task automatic test_burst_wrap();
    int k1 = 0;
    int k3 = 0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (b1_valid && k1 < 7) begin
        tests++;
        if (b1_last !== 1'b1 || b1_data !== 8'(k1)) begin
          fails++;
          $display("FAIL burst1[%0d]: last=%b data=%h, required 1 %h", k1, b1_last, b1_data, 8'(k1));
        end
        k1++;
      end
      if (b3_valid && k3 < 7) begin
        tests++;
        if (b3_last !== ((k3 % 3) == 2) || b3_data !== 8'(k3)) begin
          fails++;
          $display("FAIL burst3[%0d]: last=%b data=%h, required %b %h", k3, b3_last, b3_data,
                   (k3 % 3) == 2, 8'(k3));
        end
        k3++;
      end
    end
    tests++;
    if (k1 != 7 || k3 != 7) begin
      fails++;
      $display("FAIL burst_count: %0d/%0d beats, required 7/7", k1, k3);
    end
  endtask

  task automatic test_reset_midstream();
    int t = 0;
    logic [7:0] first;
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(8'($urandom));
    while (buf_cnt != 2'd2 && t < 20) begin @(negedge clk); t++; end
    tests++;
    if (buf_cnt !== 2'd2) begin
      fails++;
      $display("FAIL mid_setup: cnt=%0d, required 2", buf_cnt);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({rd_en, m_valid, m_last, buf_cnt, m_data} !== 13'h0) begin
      fails++;
      $display("FAIL mid_reset_outputs: en=%b v=%b l=%b cnt=%0d d=%h, required all 0",
               rd_en, m_valid, m_last, buf_cnt, m_data);
    end
    src_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    first = 8'($urandom);
    push(first);
    for (int i = 1; i < 20; i++) push(8'($urandom));
    m_ready = 1'b1;
    wait_beats(20, 80, "mid_restart");
    tests++;
    if (first_data !== first || lasts_seen != 1) begin
      fails++;
      $display("FAIL mid_restart_first: %h lasts=%0d, required %h lasts=1", first_data, lasts_seen, first);
    end
  endtask

  task automatic test_random();
    int pushed = 0;
    int t = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      tick();
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin push(8'($urandom)); pushed++; end
    end
    m_ready = 1'b1;
    while ((exp_q.size() != 0 || m_valid) && t < 100) begin tick(); t++; end
    tests++;
    if (exp_q.size() != 0 || beats_seen != pushed) begin
      fails++;
      $display("FAIL random_drain: beats=%0d left=%0d, required %0d and 0", beats_seen, exp_q.size(), pushed);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic_order();
    test_throughput();
    test_backpressure();
    test_empty_boundary();
    test_burst_wrap();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
